// File: rtl/ac_4444_seq_ctrl_if.sv
// rtl/ac_4444_seq_ctrl_if.sv - operand/result handshake bundle for ac_4444_seq_ctrl
//
// Purpose: groups the producer-side (in_*, a, b) and consumer-side (out_*, prod)
// valid/ready signals of the sequencing controller.
// Signals:
//   in_valid  producer -> ctrl   operand pair valid
//   in_ready  ctrl -> producer   controller idle and accepting
//   a, b      producer -> ctrl   operands, 2*HALF_W bits each
//   out_valid ctrl -> consumer   prod valid, held until out_ready
//   out_ready consumer -> ctrl   consumer accepts prod
//   prod      ctrl -> consumer   product, 4*HALF_W bits
// Modports: master = producer/consumer side, slave = controller side.

interface ac_4444_seq_ctrl_if #(
    parameter int HALF_W = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [2*HALF_W-1:0] a;
    logic [2*HALF_W-1:0] b;
    logic                out_valid;
    logic                out_ready;
    logic [4*HALF_W-1:0] prod;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, prod
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, prod
    );
endinterface

// File: rtl/ac_4444_seq_ctrl.sv
// rtl/ac_4444_seq_ctrl.sv - nibble-product sequencer for the 8x8 approximate multiplier
//
// Purpose: time-multiplexes one external ap4 (4x4 multiplier) over the partial
// products LL, LH, HL, HH, holds them in registers for an external add_acc, and
// returns the add_acc sum with valid/ready handshakes on both sides.
// FSM: IDLE -> CALC (one cycle per partial product) -> ACC -> OUT -> IDLE.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   bus (slave)           in_valid/in_ready/a/b and out_valid/out_ready/prod
//   pp_req_o              ap4 is being driven this cycle
//   pp_a_o, pp_b_o        ap4 operand nibbles, 0 when pp_req_o=0
//   pp_prod_i             ap4 product (combinational)
//   acc_ll_o..acc_hh_o    registered partial products to add_acc
//   acc_result_i          add_acc sum (combinational)
//   op_cnt_o              count of output handshakes, wraps
// Parameters: HALF_W (only 4 is meaningful, ap4 is fixed), CNT_W.
// Optional feature: SEQ_MUL_SKIP_ZERO_EN - partial products with a zero nibble
// operand are skipped (no cycle, no pp_req, register stays 0).

module ac_4444_seq_ctrl #(
    parameter int HALF_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ac_4444_seq_ctrl_if.slave     bus,
    output logic                  pp_req_o,
    output logic [HALF_W-1:0]     pp_a_o,
    output logic [HALF_W-1:0]     pp_b_o,
    input  logic [2*HALF_W-1:0]   pp_prod_i,
    output logic [2*HALF_W-1:0]   acc_ll_o,
    output logic [2*HALF_W-1:0]   acc_lh_o,
    output logic [2*HALF_W-1:0]   acc_hl_o,
    output logic [2*HALF_W-1:0]   acc_hh_o,
    input  logic [4*HALF_W-1:0]   acc_result_i,
    output logic [CNT_W-1:0]      op_cnt_o
);
    localparam int W = 2 * HALF_W;
    localparam int P = 4 * HALF_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_ACC,
        S_OUT
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         step_q, step_d;
    logic [3:0]         mask_q, mask_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [3:0][W-1:0]  acc_q, acc_d;
    logic [P-1:0]       prod_q, prod_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         accept_mask;
    logic [2:0]         nxt;
    logic               pp_req;
    logic [HALF_W-1:0]  pp_a, pp_b;

    // Returns {found, step} for the first step >= from whose mask bit is clear.
    // Scanning downward lets the lowest qualifying step win.
    function automatic logic [2:0] next_unmasked(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] r;
        r = 3'b000;
        for (int s = 3; s >= 0; s--) begin
            if (s >= int'(from) && !mask[s]) begin
                r = {1'b1, 2'(s)};
            end
        end
        return r;
    endfunction

`ifdef SEQ_MUL_SKIP_ZERO_EN
    // Step s uses a-nibble s[1] and b-nibble s[0]; a zero nibble makes the product zero.
    function automatic logic [3:0] zero_mask(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [3:0] m;
        for (int s = 0; s < 4; s++) begin
            m[s] = ((((s & 2) != 0) ? x[W-1:HALF_W] : x[HALF_W-1:0]) == '0) ||
                   ((((s & 1) != 0) ? y[W-1:HALF_W] : y[HALF_W-1:0]) == '0);
        end
        return m;
    endfunction

    assign accept_mask = zero_mask(bus.a, bus.b);
`else
    assign accept_mask = 4'b0000;
`endif

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        mask_d      = mask_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        nxt         = 3'b000;
        pp_req      = 1'b0;
        pp_a        = '0;
        pp_b        = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d    = bus.a;
                    b_d    = bus.b;
                    acc_d  = '0;
                    mask_d = accept_mask;
                    nxt    = next_unmasked(accept_mask, 3'd0);
                    step_d = nxt[1:0];
                    // With every step masked the product is zero and CALC is bypassed.
                    state_d = nxt[2] ? S_CALC : S_ACC;
                end
            end
            S_CALC: begin
                pp_req        = 1'b1;
                pp_a          = step_q[1] ? a_q[W-1:HALF_W] : a_q[HALF_W-1:0];
                pp_b          = step_q[0] ? b_q[W-1:HALF_W] : b_q[HALF_W-1:0];
                acc_d[step_q] = pp_prod_i;
                nxt           = next_unmasked(mask_q, {1'b0, step_q} + 3'd1);
                if (nxt[2]) begin
                    step_d = nxt[1:0];
                end else begin
                    step_d  = 2'd0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                prod_d      = acc_result_i;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            step_q      <= 2'd0;
            mask_q      <= 4'b0000;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            mask_q      <= mask_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.prod      = prod_q;
    assign pp_req_o      = pp_req;
    assign pp_a_o        = pp_a;
    assign pp_b_o        = pp_b;
    assign acc_ll_o      = acc_q[0];
    assign acc_lh_o      = acc_q[1];
    assign acc_hl_o      = acc_q[2];
    assign acc_hh_o      = acc_q[3];
    assign op_cnt_o      = cnt_q;
endmodule

// File: tb/tb_ac_4444_seq_ctrl.sv
// tb/tb_ac_4444_seq_ctrl.sv - directed self-checking bench for ac_4444_seq_ctrl

module tb_ac_4444_seq_ctrl;
    localparam int CNT_W = 4;
`ifdef SEQ_MUL_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pp_req;
    logic [3:0]  pp_a, pp_b;
    logic [7:0]  pp_prod;
    logic [7:0]  acc_ll, acc_lh, acc_hl, acc_hh;
    logic [15:0] acc_result;
    logic [CNT_W-1:0] op_cnt;

    int checks = 0;
    int fails  = 0;
    int npp;
    int exp_cnt;
    logic [3:0] seq_a [8];
    logic [3:0] seq_b [8];

    always #5 clk = ~clk;

    ac_4444_seq_ctrl_if bus ();

    // Exact ap4 and add_acc stand-ins.
    assign pp_prod    = 8'(pp_a) * 8'(pp_b);
    assign acc_result = 16'(acc_ll) + (16'(acc_lh) << 4) + (16'(acc_hl) << 4) + (16'(acc_hh) << 8);

    ac_4444_seq_ctrl #(.HALF_W(4), .CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (bus.slave),
        .pp_req_o     (pp_req),
        .pp_a_o       (pp_a),
        .pp_b_o       (pp_b),
        .pp_prod_i    (pp_prod),
        .acc_ll_o     (acc_ll),
        .acc_lh_o     (acc_lh),
        .acc_hl_o     (acc_hl),
        .acc_hh_o     (acc_hh),
        .acc_result_i (acc_result),
        .op_cnt_o     (op_cnt)
    );

    // Called at posedge+1; returns at posedge+1 of the first cycle after the accept.
    task automatic accept_op(input logic [7:0] av, input logic [7:0] bv, input bit keep, output bit ok);
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = av;
        bus.b = bv;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!keep) bus.in_valid = 1'b0;
    endtask

    // Counts cycles after the accept until out_valid, recording the ap4 operands seen.
    task automatic wait_out(output int lat);
        lat = -1;
        npp = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (pp_req) begin
                if (npp < 8) begin
                    seq_a[npp] = pp_a;
                    seq_b[npp] = pp_b;
                end
                npp++;
            end
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b expected 0", bus.out_valid); end
        checks++; if (bus.prod !== 16'h0000) begin fails++; $display("FAIL reset_prod got %h expected 0000", bus.prod); end
        checks++; if (pp_req !== 1'b0 || pp_a !== 4'h0 || pp_b !== 4'h0) begin fails++; $display("FAIL reset_pp got req=%b a=%h b=%h expected 0 0 0", pp_req, pp_a, pp_b); end
        checks++; if ({acc_ll, acc_lh, acc_hl, acc_hh} !== 32'h0) begin fails++; $display("FAIL reset_acc got %h expected 0", {acc_ll, acc_lh, acc_hl, acc_hh}); end
        checks++; if (op_cnt !== 4'd0) begin fails++; $display("FAIL reset_op_cnt got %0d expected 0", op_cnt); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_full_ones();
        bit ok;
        int lat;
        bus.out_ready = 1'b1;
        accept_op(8'hFF, 8'hFF, 1'b0, ok);
        checks++; if (ok !== 1'b1) begin fails++; $display("FAIL ff_accept got %b expected 1", ok); end
        wait_out(lat);
        checks++; if (lat != 6) begin fails++; $display("FAIL ff_latency got %0d expected 6", lat); end
        checks++; if (npp != 4) begin fails++; $display("FAIL ff_pp_cycles got %0d expected 4", npp); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (seq_a[i] !== 4'hF || seq_b[i] !== 4'hF) begin fails++; $display("FAIL ff_pp_step%0d got %h,%h expected F,F", i, seq_a[i], seq_b[i]); end
        end
        checks++; if (bus.prod !== 16'hFE01) begin fails++; $display("FAIL ff_prod got %h expected FE01", bus.prod); end
        checks++; if (acc_hh !== 8'hE1) begin fails++; $display("FAIL ff_acc_hh got %h expected E1", acc_hh); end
        @(posedge clk);
        #1;
        exp_cnt++;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL ff_valid_drop got %b expected 0", bus.out_valid); end
        checks++; if (op_cnt !== 4'(exp_cnt)) begin fails++; $display("FAIL ff_op_cnt got %0d expected %0d", op_cnt, exp_cnt); end
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL ff_idle got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        logic [3:0] ea [4];
        logic [3:0] eb [4];
        ea = '{4'h2, 4'h2, 4'h1, 4'h1};
        eb = '{4'h4, 4'h3, 4'h4, 4'h3};
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        accept_op(8'h12, 8'h34, 1'b0, ok);
        wait_out(lat);
        checks++; if (lat != 6) begin fails++; $display("FAIL bp_latency got %0d expected 6", lat); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (seq_a[i] !== ea[i] || seq_b[i] !== eb[i]) begin fails++; $display("FAIL bp_pp_order step%0d got %h,%h expected %h,%h", i, seq_a[i], seq_b[i], ea[i], eb[i]); end
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++; if (bus.prod !== 16'h03A8 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold cyc%0d got prod=%h v=%b rdy=%b expected 03A8 1 0", i, bus.prod, bus.out_valid, bus.in_ready); end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_pre_handshake got %b expected 1", bus.out_valid); end
        @(posedge clk);
        #1;
        exp_cnt++;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || op_cnt !== 4'(exp_cnt)) begin fails++; $display("FAIL bp_done got v=%b cnt=%0d expected 0 %0d", bus.out_valid, op_cnt, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int lat;
        int exp_lat;
        exp_lat = SKIP ? 3 : 6;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        accept_op(8'h03, 8'h05, 1'b1, ok);
        bus.a = 8'h10;
        bus.b = 8'h10;
        wait_out(lat);
        checks++; if (lat != exp_lat) begin fails++; $display("FAIL b2b_lat1 got %0d expected %0d", lat, exp_lat); end
        checks++; if (bus.prod !== 16'h000F) begin fails++; $display("FAIL b2b_prod1 got %h expected 000F", bus.prod); end
        @(negedge clk);
        exp_cnt++;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_gap got rdy=%b v=%b expected 1 0", bus.in_ready, bus.out_valid); end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_out(lat);
        checks++; if (lat != exp_lat) begin fails++; $display("FAIL b2b_lat2 got %0d expected %0d", lat, exp_lat); end
        checks++; if (bus.prod !== 16'h0100) begin fails++; $display("FAIL b2b_prod2 got %h expected 0100", bus.prod); end
        @(posedge clk);
        #1;
        exp_cnt++;
        @(negedge clk);
        checks++; if (op_cnt !== 4'(exp_cnt)) begin fails++; $display("FAIL b2b_op_cnt got %0d expected %0d", op_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid_calc();
        bit ok;
        int seen;
        @(posedge clk);
        #1;
        accept_op(8'hA5, 8'h5A, 1'b0, ok);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (pp_req !== 1'b1 || pp_a !== 4'hA || pp_b !== 4'hA) begin fails++; $display("FAIL rst_step2_pp got req=%b a=%h b=%h expected 1 A A", pp_req, pp_a, pp_b); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_state got rdy=%b v=%b expected 1 0", bus.in_ready, bus.out_valid); end
        checks++; if (bus.prod !== 16'h0000) begin fails++; $display("FAIL rst_mid_prod got %h expected 0000", bus.prod); end
        checks++; if ({acc_ll, acc_lh, acc_hl, acc_hh} !== 32'h0) begin fails++; $display("FAIL rst_mid_acc got %h expected 0", {acc_ll, acc_lh, acc_hl, acc_hh}); end
        checks++; if (pp_req !== 1'b0 || op_cnt !== 4'd0) begin fails++; $display("FAIL rst_mid_pp_cnt got req=%b cnt=%0d expected 0 0", pp_req, op_cnt); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin fails++; $display("FAIL rst_mid_no_output got %0d valid cycles expected 0", seen); end
    endtask

    task automatic test_skip_zero();
        bit ok;
        int lat;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        accept_op(8'h0F, 8'h0F, 1'b0, ok);
        wait_out(lat);
        checks++; if (lat != (SKIP ? 3 : 6)) begin fails++; $display("FAIL skip_0f_latency got %0d expected %0d", lat, SKIP ? 3 : 6); end
        checks++; if (npp != (SKIP ? 1 : 4)) begin fails++; $display("FAIL skip_0f_pp_cycles got %0d expected %0d", npp, SKIP ? 1 : 4); end
        checks++; if (bus.prod !== 16'h00E1 || acc_ll !== 8'hE1) begin fails++; $display("FAIL skip_0f_prod got %h ll=%h expected 00E1 E1", bus.prod, acc_ll); end
        @(posedge clk);
        #1;
        exp_cnt++;
        accept_op(8'h00, 8'h37, 1'b0, ok);
        wait_out(lat);
        checks++; if (lat != (SKIP ? 2 : 6)) begin fails++; $display("FAIL skip_00_latency got %0d expected %0d", lat, SKIP ? 2 : 6); end
        checks++; if (npp != (SKIP ? 0 : 4)) begin fails++; $display("FAIL skip_00_pp_cycles got %0d expected %0d", npp, SKIP ? 0 : 4); end
        checks++; if (bus.prod !== 16'h0000) begin fails++; $display("FAIL skip_00_prod got %h expected 0000", bus.prod); end
        @(posedge clk);
        #1;
        exp_cnt++;
    endtask

    task automatic test_op_cnt_wrap();
        bit ok;
        int lat;
        int guard;
        logic [7:0] av, bv;
        logic [15:0] ep;
        guard = 0;
        while (exp_cnt != 15 && guard < 20) begin
            av = 8'(17 * guard + 3);
            bv = 8'(29 * guard + 1);
            ep = 16'(av) * 16'(bv);
            accept_op(av, bv, 1'b0, ok);
            wait_out(lat);
            checks++; if (bus.prod !== ep) begin fails++; $display("FAIL wrap_prod %h*%h got %h expected %h", av, bv, bus.prod, ep); end
            @(posedge clk);
            #1;
            exp_cnt++;
            guard++;
        end
        @(negedge clk);
        checks++; if (op_cnt !== 4'd15) begin fails++; $display("FAIL wrap_at_15 got %0d expected 15", op_cnt); end
        @(posedge clk);
        #1;
        accept_op(8'h21, 8'h43, 1'b0, ok);
        wait_out(lat);
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (op_cnt !== 4'd0) begin fails++; $display("FAIL wrap_to_0 got %0d expected 0", op_cnt); end
        checks++; if (bus.prod !== 16'h08A3) begin fails++; $display("FAIL wrap_last_prod got %h expected 08A3", bus.prod); end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = 8'h00;
        bus.b = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_full_ones();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_calc();
        test_skip_zero();
        test_op_cnt_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got no finish expected finish");
        $fatal(1);
    end
endmodule
